// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel-rate counters, sync/blank decode and a
// lookahead tile-RAM read port so data of latency RD_LATENCY lines up with the pixel.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int CLK_DIV    = 2,
  parameter int TILE_SHIFT = 4,
  parameter int GRID_COLS  = 40,
  parameter int GRID_ROWS  = 30,
  parameter int RD_LATENCY = 1,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int CW        = $clog2(H_TOTAL),
  localparam int RW        = $clog2(V_TOTAL),
  localparam int AW        = $clog2(GRID_COLS * GRID_ROWS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic          pix_tick,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic          line_end,
  output logic          frame_end,
  output logic          re,
  output logic [AW-1:0] raddr
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST    = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST      = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT       = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_START    = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END      = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [RW-1:0] V_LAST      = RW'(V_TOTAL - 1);
  localparam logic [RW-1:0] V_ACT       = RW'(V_ACTIVE);
  localparam logic [RW-1:0] VS_START    = RW'(V_ACTIVE + V_FP);
  localparam logic [RW-1:0] VS_END      = RW'(V_ACTIVE + V_FP + V_SYNC - 1);
  // RD_LATENCY never exceeds the front porch, so the lookahead start stays on line 0.
  localparam logic [CW-1:0] COL_LA_INIT = CW'(RD_LATENCY);

  logic [DW-1:0] divider;
  logic [CW-1:0] col_la, col_next, col_la_next;
  logic [RW-1:0] row_la, row_next, row_la_next;
  logic [AW-1:0] raddr_calc, raddr_hold;

  // Gated by reset so no strobe escapes while reset is held, even with CLK_DIV=1.
  assign pix_tick  = en && reset && (divider == DIV_LAST);
  assign line_end  = pix_tick && (col == H_LAST);
  assign frame_end = line_end && (row == V_LAST);
  assign video_on  = (col < H_ACT) && (row < V_ACT);
  assign hsync     = (col >= HS_START && col <= HS_END) ? HSYNC_POL : ~HSYNC_POL;
  assign vsync     = (row >= VS_START && row <= VS_END) ? VSYNC_POL : ~VSYNC_POL;
  assign re        = pix_tick && (col_la < H_ACT) && (row_la < V_ACT);
  assign raddr     = re ? raddr_calc : raddr_hold;

  // Low AW bits of the product depend only on the low AW bits of each operand.
  always_comb begin
    raddr_calc = AW'(row_la >> TILE_SHIFT) * AW'(GRID_COLS) + AW'(col_la >> TILE_SHIFT);
  end

  always_comb begin
    col_next    = col + CW'(1);
    row_next    = row;
    col_la_next = col_la + CW'(1);
    row_la_next = row_la;
    if (col == H_LAST) begin
      col_next = '0;
      row_next = (row == V_LAST) ? '0 : row + RW'(1);
    end
    if (col_la == H_LAST) begin
      col_la_next = '0;
      row_la_next = (row_la == V_LAST) ? '0 : row_la + RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      divider <= '0;
    end else if (en) begin
      divider <= (divider == DIV_LAST) ? '0 : divider + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col    <= '0;
      row    <= '0;
      col_la <= COL_LA_INIT;
      row_la <= '0;
    end else if (pix_tick) begin
      col    <= col_next;
      row    <= row_next;
      col_la <= col_la_next;
      row_la <= row_la_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      raddr_hold <= '0;
    end else if (re) begin
      raddr_hold <= raddr_calc;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, fast/positive-hsync and small-geometry instances,
// checked by a per-cycle scoreboard plus a vector table and hand-written sequences.
module tb_vga_timing_gen;

  typedef struct packed {
    logic        pix_tick, line_end, frame_end, hsync, vsync, video_on, re;
    logic [15:0] col, row, raddr;
  } obs_t;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, hpol, vpol, div, ts, gc, lat, aw;
  } geom_t;

  typedef struct { int inst; obs_t o; } sb_t;

  typedef struct {
    int   row, col;
    logic re;
    int   raddr;
    logic hs, vs, vo;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic en = 1'b1;

  logic       pt0, hs0, vs0, vo0, le0, fe0, re0;
  logic [9:0] col0, row0;
  logic [10:0] ra0;
  logic       pt1, hs1, vs1, vo1, le1, fe1, re1;
  logic [9:0] col1, row1;
  logic [10:0] ra1;
  logic       pt2, hs2, vs2, vo2, le2, fe2, re2;
  logic [4:0] col2;
  logic [3:0] row2;
  logic [2:0] ra2;

  int checks = 0;
  int errors = 0;
  geom_t geo [3];
  longint mk [3];
  int md [3];
  int mlra [3];
  bit armed = 1'b0;
  sb_t sbq [$];
  vec_t tbl [12];

  always #5 clk = ~clk;

  vga_timing_gen dut0 (
    .clk(clk), .reset(reset), .en(en), .pix_tick(pt0), .col(col0), .row(row0),
    .hsync(hs0), .vsync(vs0), .video_on(vo0), .line_end(le0), .frame_end(fe0),
    .re(re0), .raddr(ra0)
  );

  vga_timing_gen #(.CLK_DIV(1), .HSYNC_POL(1'b1)) dut1 (
    .clk(clk), .reset(reset), .en(en), .pix_tick(pt1), .col(col1), .row(row1),
    .hsync(hs1), .vsync(vs1), .video_on(vo1), .line_end(le1), .frame_end(fe1),
    .re(re1), .raddr(ra1)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(2), .V_SYNC(2),
    .V_BP(2), .TILE_SHIFT(2), .GRID_COLS(4), .GRID_ROWS(2), .RD_LATENCY(2)
  ) dut2 (
    .clk(clk), .reset(reset), .en(en), .pix_tick(pt2), .col(col2), .row(row2),
    .hsync(hs2), .vsync(vs2), .video_on(vo2), .line_end(le2), .frame_end(fe2),
    .re(re2), .raddr(ra2)
  );

  function automatic obs_t get_act(input int i);
    obs_t a;
    case (i)
      0: a = {pt0, le0, fe0, hs0, vs0, vo0, re0, 16'(col0), 16'(row0), 16'(ra0)};
      1: a = {pt1, le1, fe1, hs1, vs1, vo1, re1, 16'(col1), 16'(row1), 16'(ra1)};
      default: a = {pt2, le2, fe2, hs2, vs2, vo2, re2, 16'(col2), 16'(row2), 16'(ra2)};
    endcase
    return a;
  endfunction

  // Reference: position derived from the number of pixel ticks since reset.
  function automatic obs_t model_out(input geom_t g, input longint k, input int d,
                                     input logic en_i, input logic rst_i, input int last_ra);
    obs_t o;
    int ht, vt, c, r, cl, rl;
    longint fr, p, pl;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    fr = longint'(ht) * vt;
    p  = k % fr;
    pl = (k + g.lat) % fr;
    c  = int'(p % ht);
    r  = int'(p / ht);
    cl = int'(pl % ht);
    rl = int'(pl / ht);
    o.pix_tick  = en_i && rst_i && (d == g.div - 1);
    o.col       = 16'(c);
    o.row       = 16'(r);
    o.video_on  = (c < g.ha) && (r < g.va);
    o.hsync     = (c >= g.ha + g.hfp && c < g.ha + g.hfp + g.hs) ? 1'(g.hpol) : !1'(g.hpol);
    o.vsync     = (r >= g.va + g.vfp && r < g.va + g.vfp + g.vs) ? 1'(g.vpol) : !1'(g.vpol);
    o.line_end  = o.pix_tick && (c == ht - 1);
    o.frame_end = o.line_end && (r == vt - 1);
    o.re        = o.pix_tick && (cl < g.ha) && (rl < g.va);
    o.raddr     = o.re ? 16'((((rl >> g.ts) * g.gc) + (cl >> g.ts)) & ((1 << g.aw) - 1))
                       : 16'(last_ra);
    return o;
  endfunction

  // Scoreboard producer: advance the model at each edge and queue the expected outputs.
  initial begin
    obs_t pre;
    sb_t  s;
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        pre = model_out(geo[i], mk[i], md[i], en, reset, mlra[i]);
        if (!reset) begin
          mk[i] = 0; md[i] = 0; mlra[i] = 0;
        end else begin
          if (pre.re) mlra[i] = int'(pre.raddr);
          if (en) begin
            if (md[i] == geo[i].div - 1) begin md[i] = 0; mk[i]++; end
            else md[i]++;
          end
        end
      end
      if (!reset) armed = 1'b1;
      if (armed) begin
        for (int i = 0; i < 3; i++) begin
          s.inst = i;
          s.o = model_out(geo[i], mk[i], md[i], en, reset, mlra[i]);
          sbq.push_back(s);
        end
      end
    end
  end

  // Scoreboard consumer: compare on the falling edge, away from register updates.
  initial begin
    sb_t  e;
    obs_t a;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        a = get_act(e.inst);
        checks++;
        if (a !== e.o) begin
          errors++;
          $display("FAIL sb inst%0d t=%0t act pt%b le%b fe%b hs%b vs%b vo%b re%b c%0d r%0d a%0d exp pt%b le%b fe%b hs%b vs%b vo%b re%b c%0d r%0d a%0d",
                   e.inst, $time, a.pix_tick, a.line_end, a.frame_end, a.hsync, a.vsync,
                   a.video_on, a.re, a.col, a.row, a.raddr, e.o.pix_tick, e.o.line_end,
                   e.o.frame_end, e.o.hsync, e.o.vsync, e.o.video_on, e.o.re, e.o.col,
                   e.o.row, e.o.raddr);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endtask

  initial begin
    bit found;
    int n;
    geo[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 0, 2, 4, 40, 1, 11};
    geo[1] = '{640, 16, 96, 48, 480, 10, 2, 33, 1, 0, 1, 4, 40, 1, 11};
    geo[2] = '{16, 2, 3, 3, 8, 2, 2, 2, 0, 0, 2, 2, 4, 2, 3};

    //          row  col  re raddr hs vs vo
    tbl[0]  = '{0,   0,   1, 0,    1, 1, 1};
    tbl[1]  = '{0,   15,  1, 1,    1, 1, 1};
    tbl[2]  = '{0,   639, 0, 39,   1, 1, 1};
    tbl[3]  = '{0,   655, 0, 39,   1, 1, 0};
    tbl[4]  = '{0,   656, 0, 39,   0, 1, 0};
    tbl[5]  = '{0,   751, 0, 39,   0, 1, 0};
    tbl[6]  = '{0,   752, 0, 39,   1, 1, 0};
    tbl[7]  = '{0,   799, 1, 0,    1, 1, 0};
    tbl[8]  = '{1,   17,  1, 1,    1, 1, 1};
    tbl[9]  = '{15,  799, 1, 40,   1, 1, 0};
    tbl[10] = '{16,  0,   1, 40,   1, 1, 1};
    tbl[11] = '{16,  639, 0, 79,   1, 1, 1};

    reset = 1'b0;
    en    = 1'b1;
    repeat (3) step();
    reset = 1'b1;

    for (int v = 0; v < 12; v++) begin
      found = 1'b0;
      for (int t = 0; t < 40000 && !found; t++) begin
        step();
        if (pt0 && col0 == 10'(tbl[v].col) && row0 == 10'(tbl[v].row)) found = 1'b1;
      end
      if (!found) timeout($sformatf("vec%0d", v));
      else begin
        $display("vec %0d (%0d,%0d) re=%b raddr=%0d hs=%b vs=%b vo=%b",
                 v, row0, col0, re0, ra0, hs0, vs0, vo0);
        check_val($sformatf("vec%0d re", v), 32'(re0), 32'(tbl[v].re));
        check_val($sformatf("vec%0d raddr", v), 32'(ra0), 32'(tbl[v].raddr));
        check_val($sformatf("vec%0d hsync", v), 32'(hs0), 32'(tbl[v].hs));
        check_val($sformatf("vec%0d vsync", v), 32'(vs0), 32'(tbl[v].vs));
        check_val($sformatf("vec%0d video_on", v), 32'(vo0), 32'(tbl[v].vo));
      end
    end

    // Freeze at (17,200) for 10 clks, then resume.
    found = 1'b0;
    for (int t = 0; t < 4000 && !found; t++) begin
      step();
      if (col0 == 10'd200) found = 1'b1;
    end
    if (!found) timeout("freeze_wait");
    en = 1'b0;
    for (int t = 0; t < 10; t++) begin
      step();
      check_val("freeze col", 32'(col0), 32'd200);
      check_val("freeze row", 32'(row0), 32'd17);
      check_val("freeze pix_tick", 32'(pt0), 32'd0);
      check_val("freeze re", 32'(re0), 32'd0);
      check_val("freeze pix_tick1", 32'(pt1), 32'd0);
    end
    en = 1'b1;
    $display("resume at (%0d,%0d)", row0, col0);
    step();
    check_val("resume col+1clk", 32'(col0), 32'd200);
    step();
    check_val("resume col+2clk", 32'(col0), 32'd201);

    // Reset mid-line.
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      step();
      if (col0 == 10'd400) found = 1'b1;
    end
    if (!found) timeout("reset_wait");
    reset = 1'b0;
    step();
    $display("mid-line reset applied");
    check_val("rst col", 32'(col0), 32'd0);
    check_val("rst row", 32'(row0), 32'd0);
    check_val("rst hsync", 32'(hs0), 32'd1);
    check_val("rst vsync", 32'(vs0), 32'd1);
    check_val("rst re", 32'(re0), 32'd0);
    check_val("rst pix_tick", 32'(pt0), 32'd0);
    check_val("rst pix_tick1", 32'(pt1), 32'd0);
    check_val("rst hsync1", 32'(hs1), 32'd0);
    check_val("rst col2", 32'(col2), 32'd0);
    reset = 1'b1;

    // Small geometry: 24 x 14 pixels at 2 clks each.
    n = 0;
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      step();
      n++;
      if (fe2) found = 1'b1;
    end
    if (!found) timeout("frame_end first");
    else check_val("frame_end after release", 32'(n), 32'(24 * 14 * 2 - 1));
    n = 0;
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      step();
      n++;
      if (fe2) found = 1'b1;
    end
    if (!found) timeout("frame_end period");
    else check_val("frame_end period", 32'(n), 32'd672);
    $display("small frame period %0d clks", n);

    // line_end spacing on the default instance.
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      step();
      if (le0) found = 1'b1;
    end
    if (!found) timeout("line_end first");
    n = 0;
    found = 1'b0;
    for (int t = 0; t < 2000 && !found; t++) begin
      step();
      n++;
      if (le0) found = 1'b1;
    end
    if (!found) timeout("line_end period");
    else check_val("line_end period", 32'(n), 32'd1600);
    $display("line period %0d clks", n);

    // CLK_DIV=1, active-high hsync instance.
    n = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (pt1) n++;
    end
    check_val("pix_tick1 count", 32'(n), 32'd20);
    found = 1'b0;
    for (int t = 0; t < 1000 && !found; t++) begin
      step();
      if (col1 == 10'd700) found = 1'b1;
    end
    if (!found) timeout("hsync1 wait");
    else check_val("hsync1 in pulse", 32'(hs1), 32'd1);
    step();
    step();
    found = 1'b0;
    for (int t = 0; t < 1000 && !found; t++) begin
      step();
      if (col1 == 10'd752) found = 1'b1;
    end
    if (!found) timeout("hsync1 end wait");
    else check_val("hsync1 after pulse", 32'(hs1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
